mm_job_sequencer: RTL and testbench

Top-level job controller for the matrix-multiply core. Per job it accepts N_LOAD operand words from a host over a valid/ready stream and writes them into the operand RAM. It then pulses the start input of the MM control unit and waits for its done indication. Finally it streams N_OUT result words out of the result RAM over a valid/ready stream. It owns both RAM ports outside compute, so the host never touches the RAMs directly.

---
 rtl/mm_pkg.sv | 20 ++
 rtl/mm_job_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mm_job_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply core: sequencer state encoding
// and default geometry used by the control unit and the job sequencer.
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_RD      = 3'd4,
        ST_HOLD    = 3'd5
    } seq_state_e;

    localparam int MM_DW      = 8;
    localparam int MM_AW      = 5;
    localparam int MM_N_LOAD  = 20;
    localparam int MM_N_OUT   = 4;
    localparam int MM_TIMEOUT = 64;

endpackage

// File: rtl/mm_job_sequencer.sv
// Job controller for the MM core: loads operands, starts compute, drains results.
// Optional compute watchdog with err output: define MM_SEQ_TIMEOUT_EN.
module mm_job_sequencer
    import mm_pkg::*;
#(
    parameter int DW     = MM_DW,
    parameter int AW     = MM_AW,
    parameter int N_LOAD = MM_N_LOAD,
    parameter int N_OUT  = MM_N_OUT
`ifdef MM_SEQ_TIMEOUT_EN
    ,parameter int TIMEOUT = MM_TIMEOUT
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          ram_in_we,
    output logic [AW-1:0] ram_in_addr,
    output logic [DW-1:0] ram_in_wdata,
    output logic          mm_start,
    input  logic          mm_done,
    output logic [AW-1:0] ram_out_addr,
    input  logic [DW-1:0] ram_out_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
`ifdef MM_SEQ_TIMEOUT_EN
    ,output logic         err
`endif
);

    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] LOAD_LAST = CW'(N_LOAD - 1);
    localparam logic [CW-1:0] OUT_LAST  = CW'(N_OUT - 1);

    seq_state_e    state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [DW-1:0] out_data_nxt_s;
    logic          out_valid_nxt_s, out_last_nxt_s;
    logic          drain_s;

`ifdef MM_SEQ_TIMEOUT_EN
    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_r, wd_nxt_s;
    logic           err_nxt_s;
`endif

    assign cnt_inc_s = cnt_r + CW'(1);
    assign drain_s   = out_valid & out_ready;

    // Next-state, counter and combinational port decode.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        out_data_nxt_s  = out_data;
        out_valid_nxt_s = out_valid;
        out_last_nxt_s  = out_last;
        in_ready        = 1'b0;
        ram_in_we       = 1'b0;
        ram_in_addr     = '0;
        ram_in_wdata    = '0;
        mm_start        = 1'b0;
        ram_out_addr    = '0;
        busy            = (state_r != ST_IDLE);
`ifdef MM_SEQ_TIMEOUT_EN
        wd_nxt_s        = wd_r;
        err_nxt_s       = err;
`endif
        case (state_r)
            ST_IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    ram_in_we    = 1'b1;
                    ram_in_wdata = in_data;
                    cnt_nxt_s    = CW'(1);
                    state_nxt_s  = (N_LOAD == 1) ? ST_START : ST_LOAD;
`ifdef MM_SEQ_TIMEOUT_EN
                    err_nxt_s    = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    ram_in_we    = 1'b1;
                    ram_in_addr  = cnt_r[AW-1:0];
                    ram_in_wdata = in_data;
                    if (cnt_r == LOAD_LAST) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_START;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_START: begin
                mm_start    = 1'b1;
                state_nxt_s = ST_COMPUTE;
`ifdef MM_SEQ_TIMEOUT_EN
                wd_nxt_s    = '0;
`endif
            end
            ST_COMPUTE: begin
                // Address 0 is issued early so its read data is ready during RD.
                if (mm_done) begin
                    cnt_nxt_s    = '0;
                    ram_out_addr = '0;
                    state_nxt_s  = ST_RD;
                end
`ifdef MM_SEQ_TIMEOUT_EN
                else if (wd_r == WD_LAST) begin
                    cnt_nxt_s   = '0;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    wd_nxt_s = wd_r + WDW'(1);
                end
`else
                else begin
                    state_nxt_s = ST_COMPUTE;
                end
`endif
            end
            ST_RD: begin
                ram_out_addr    = cnt_r[AW-1:0];
                out_data_nxt_s  = ram_out_rdata;
                out_valid_nxt_s = 1'b1;
                out_last_nxt_s  = (cnt_r == OUT_LAST);
                state_nxt_s     = ST_HOLD;
            end
            ST_HOLD: begin
                ram_out_addr = cnt_r[AW-1:0];
                if (drain_s) begin
                    out_valid_nxt_s = 1'b0;
                    out_last_nxt_s  = 1'b0;
                    if (out_last) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s    = cnt_inc_s;
                        ram_out_addr = cnt_inc_s[AW-1:0];
                        state_nxt_s  = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                cnt_nxt_s       = '0;
                out_valid_nxt_s = 1'b0;
                out_last_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, shared counter and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef MM_SEQ_TIMEOUT_EN
            wd_r      <= '0;
            err       <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            out_data  <= out_data_nxt_s;
            out_valid <= out_valid_nxt_s;
            out_last  <= out_last_nxt_s;
`ifdef MM_SEQ_TIMEOUT_EN
            wd_r      <= wd_nxt_s;
            err       <= err_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Randomized self-checking bench for mm_job_sequencer with RAM models and a
// transaction-level expectation of writes, start pulses and result words.
module tb_mm_job_sequencer;
    import mm_pkg::*;

    localparam int DW      = 8;
    localparam int AW      = 5;
    localparam int N_LOAD  = 20;
    localparam int N_OUT   = 4;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid, in_ready, ram_in_we, mm_start, mm_done;
    logic          out_valid, out_ready, out_last, busy;
    logic [DW-1:0] in_data, ram_in_wdata, ram_out_rdata, out_data;
    logic [AW-1:0] ram_in_addr, ram_out_addr;
`ifdef MM_SEQ_TIMEOUT_EN
    logic          err;
`endif

    logic [DW-1:0] op_mem  [2**AW];
    logic [DW-1:0] res_mem [2**AW];
    logic [DW-1:0] ops     [N_LOAD];
    logic [DW-1:0] res_exp [N_OUT];
    int n_vec = 0;
    int n_err = 0;
    int cyc_g = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    mm_job_sequencer #(.DW(DW), .AW(AW), .N_LOAD(N_LOAD), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ram_in_we(ram_in_we), .ram_in_addr(ram_in_addr), .ram_in_wdata(ram_in_wdata),
        .mm_start(mm_start), .mm_done(mm_done),
        .ram_out_addr(ram_out_addr), .ram_out_rdata(ram_out_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
`ifdef MM_SEQ_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Operand RAM sink and result RAM with one-cycle synchronous read.
    always @(posedge clk) begin
        cyc_g <= cyc_g + 1;
        if (ram_in_we) op_mem[ram_in_addr] <= ram_in_wdata;
        ram_out_rdata <= res_mem[ram_out_addr];
    end

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic gen_job(input bit fixed);
        for (int i = 0; i < 2**AW; i++) res_mem[i] = DW'($urandom);
        for (int i = 0; i < N_LOAD; i++) ops[i] = fixed ? DW'(i + 1) : DW'($urandom);
        for (int i = 0; i < N_OUT; i++) begin
            res_exp[i] = fixed ? DW'(8'hA0 + i) : DW'($urandom);
            res_mem[i] = res_exp[i];
        end
    endtask

    // Offer n operand words; gap_pct < 0 means strict 1,0,1,0 valid toggling.
    task automatic send_words(input int n, input int gap_pct);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 1000) begin
            @(posedge clk); #1;
            in_valid = (gap_pct < 0) ? (guard % 2 == 0) : ($urandom_range(99) >= gap_pct);
            in_data  = ops[idx];
            @(negedge clk);
            if (in_valid && in_ready) begin
                expect_eq("wr_en", 32'(ram_in_we), 32'd1);
                expect_eq("wr_addr", 32'(ram_in_addr), 32'(idx));
                expect_eq("wr_data", 32'(ram_in_wdata), 32'(ops[idx]));
                if (idx == 0) first_cyc = cyc_g;
                idx++;
            end else begin
                expect_eq("wr_on_gap", 32'(ram_in_we), 32'd0);
            end
            expect_eq("start_in_load", 32'(mm_start), 32'd0);
            guard++;
        end
        expect_eq("load_budget", 32'(idx), 32'(n));
    endtask

    // Respond to mm_start and collect result words until the last one drains.
    task automatic drain_job(input int done_dly, input bit early_done, input int bp_pct,
                             input bit bp_word1, input bit check_lat);
        int out_idx = 0;
        int starts = 0;
        int since = -1;
        int bp_cnt = 0;
        int guard = 0;
        bit out_seen = 1'b0;
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        while (out_idx < N_OUT && guard < 2000) begin
            @(posedge clk); #1;
            if (since >= 0) since++;
            mm_done   = early_done ? 1'b1 : (since >= done_dly && !out_seen);
            in_valid  = 1'($urandom_range(1));
            in_data   = DW'($urandom);
            out_ready = bp_word1 ? !(out_idx == 1 && bp_cnt < 5) : ($urandom_range(99) >= bp_pct);
            @(negedge clk);
            expect_eq("in_ready_busy", 32'(in_ready), 32'd0);
            expect_eq("wr_busy", 32'(ram_in_we), 32'd0);
            if (mm_start) begin
                starts++;
                expect_eq("start_once", 32'(starts), 32'd1);
                since = 0;
            end
            if (prev_stall) begin
                expect_eq("hold_valid", 32'(out_valid), 32'd1);
                expect_eq("hold_data", 32'(out_data), 32'(prev_data));
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                out_seen = 1'b1;
                expect_eq("out_data", 32'(out_data), 32'(res_exp[out_idx]));
                expect_eq("out_last", 32'(out_last), 32'(out_idx == N_OUT - 1));
                if (out_ready) begin
                    if (out_idx == N_OUT - 1) last_cyc = cyc_g;
                    out_idx++;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                    if (bp_word1 && out_idx == 1) bp_cnt++;
                end
            end
            guard++;
        end
        expect_eq("drain_budget", 32'(out_idx), 32'(N_OUT));
        expect_eq("start_pulses", 32'(starts), 32'd1);
        if (check_lat)
            expect_eq("latency", 32'(last_cyc - first_cyc + 1), 32'(N_LOAD + 1 + done_dly + 2 * N_OUT));
        for (int i = 0; i < N_LOAD; i++) expect_eq("op_mem", 32'(op_mem[i]), 32'(ops[i]));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(1));
            if (!early_done) mm_done = 1'b0;
            @(negedge clk);
            expect_eq("idle_busy", 32'(busy), 32'd0);
            expect_eq("idle_valid", 32'(out_valid), 32'd0);
            expect_eq("idle_start", 32'(mm_start), 32'd0);
        end
        mm_done = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        expect_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        expect_eq({tag, "_we"}, 32'(ram_in_we), 32'd0);
        expect_eq({tag, "_waddr"}, 32'(ram_in_addr), 32'd0);
        expect_eq({tag, "_wdata"}, 32'(ram_in_wdata), 32'd0);
        expect_eq({tag, "_start"}, 32'(mm_start), 32'd0);
        expect_eq({tag, "_raddr"}, 32'(ram_out_addr), 32'd0);
        expect_eq({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        expect_eq({tag, "_odata"}, 32'(out_data), 32'd0);
        expect_eq({tag, "_olast"}, 32'(out_last), 32'd0);
        expect_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        mm_done   = 1'b1;
        out_ready = 1'b1;
        #1 rst = 1'b1;
        #2 check_zero_outputs("reset");
`ifdef MM_SEQ_TIMEOUT_EN
        expect_eq("reset_err", 32'(err), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        mm_done  = 1'b0;
        @(negedge clk);
        expect_eq("idle_in_ready", 32'(in_ready), 32'd1);
        expect_eq("idle_busy0", 32'(busy), 32'd0);

        // Nominal job with ideal host, done after 10 cycles.
        gen_job(1'b1);
        send_words(N_LOAD, 0);
        drain_job(10, 1'b0, 0, 1'b0, 1'b1);

        // Host toggling valid.
        gen_job(1'b0);
        send_words(N_LOAD, -1);
        drain_job(int'($urandom_range(8, 1)), 1'b0, 0, 1'b0, 1'b0);

        // Output backpressure on the second word.
        gen_job(1'b1);
        send_words(N_LOAD, 0);
        drain_job(3, 1'b0, 0, 1'b1, 1'b0);

        // mm_done high from the START cycle onward.
        gen_job(1'b0);
        send_words(N_LOAD, 0);
        drain_job(1, 1'b1, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a load.
        gen_job(1'b0);
        send_words(7, 0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = ops[7];
        #2 rst = 1'b1;
        #1 check_zero_outputs("midrst");
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        gen_job(1'b0);
        send_words(N_LOAD, 0);
        drain_job(int'($urandom_range(12, 1)), 1'b0, 30, 1'b0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            gen_job(1'b0);
            send_words(N_LOAD, int'($urandom_range(60)));
            drain_job(int'($urandom_range(20, 1)), 1'b0, int'($urandom_range(60)), 1'b0, 1'b0);
        end

`ifdef MM_SEQ_TIMEOUT_EN
        // Watchdog: mm_done never arrives.
        gen_job(1'b0);
        send_words(N_LOAD, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        mm_done  = 1'b0;
        @(negedge clk);
        expect_eq("wd_start", 32'(mm_start), 32'd1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            expect_eq("wd_busy", 32'(busy), 32'd1);
            expect_eq("wd_no_out", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        expect_eq("wd_idle", 32'(busy), 32'd0);
        expect_eq("wd_err", 32'(err), 32'd1);
        expect_eq("wd_in_ready", 32'(in_ready), 32'd1);
        gen_job(1'b0);
        send_words(N_LOAD, 0);
        expect_eq("wd_err_clear", 32'(err), 32'd0);
        drain_job(5, 1'b0, 0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
